// File: rtl/shift_reg_universal_if.sv
// Signal bundle for shift_reg_universal: control/data in from the master, register state out.
// With SHIFT_REG_ROTATE_EN defined, the bundle also carries the rot input.
interface shift_reg_universal_if #(
  parameter int WIDTH = 8
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [1:0]       mode;
  logic [WIDTH-1:0] d;
  logic             ser_msb;
  logic             ser_lsb;
`ifdef SHIFT_REG_ROTATE_EN
  logic             rot;
`endif
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_n;
  logic             sout_r;
  logic             sout_l;
  logic [CW-1:0]    cnt;
  logic             done;

`ifdef SHIFT_REG_ROTATE_EN
  modport master (
    output mode, d, ser_msb, ser_lsb, rot,
    input  q, q_n, sout_r, sout_l, cnt, done
  );
  modport slave (
    input  mode, d, ser_msb, ser_lsb, rot,
    output q, q_n, sout_r, sout_l, cnt, done
  );
`else
  modport master (
    output mode, d, ser_msb, ser_lsb,
    input  q, q_n, sout_r, sout_l, cnt, done
  );
  modport slave (
    input  mode, d, ser_msb, ser_lsb,
    output q, q_n, sout_r, sout_l, cnt, done
  );
`endif
endinterface

// File: rtl/shift_reg_universal.sv
// Universal WIDTH-bit register: hold / shift right / shift left / parallel load, with a
// saturating shift counter. Define SHIFT_REG_ROTATE_EN to add recirculating shifts via rot.
module shift_reg_universal #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  shift_reg_universal_if.slave bus
);
  localparam int            CW      = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_next;
  logic [CW-1:0]    cnt_r;
  logic [CW-1:0]    cnt_next;
  logic [CW-1:0]    cnt_sat;
  logic             fill_msb;
  logic             fill_lsb;

`ifdef SHIFT_REG_ROTATE_EN
  assign fill_msb = bus.rot ? q_r[0]       : bus.ser_msb;
  assign fill_lsb = bus.rot ? q_r[WIDTH-1] : bus.ser_lsb;
`else
  assign fill_msb = bus.ser_msb;
  assign fill_lsb = bus.ser_lsb;
`endif

  // Counter sticks at WIDTH; q keeps shifting regardless.
  assign cnt_sat = (cnt_r == CNT_MAX) ? CNT_MAX : cnt_r + CW'(1);

  always_comb begin
    q_next   = q_r;
    cnt_next = cnt_r;
    case (bus.mode)
      2'b01: begin
        q_next   = {fill_msb, q_r[WIDTH-1:1]};
        cnt_next = cnt_sat;
      end
      2'b10: begin
        q_next   = {q_r[WIDTH-2:0], fill_lsb};
        cnt_next = cnt_sat;
      end
      2'b11: begin
        q_next   = bus.d;
        cnt_next = '0;
      end
      default: begin
        q_next   = q_r;
        cnt_next = cnt_r;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r   <= RESET_VALUE;
      cnt_r <= '0;
    end else begin
      q_r   <= q_next;
      cnt_r <= cnt_next;
    end
  end

  assign bus.q      = q_r;
  assign bus.q_n    = ~q_r;
  assign bus.sout_r = q_r[0];
  assign bus.sout_l = q_r[WIDTH-1];
  assign bus.cnt    = cnt_r;
  assign bus.done   = (cnt_r == CNT_MAX);
endmodule
